// File: rtl/aes_sbox_array_stream_pkg.sv
// aes_sbox_array_stream_pkg: randomness width helpers and GF(2^8) S-box arithmetic for the streaming S-box array.
package aes_sbox_array_stream_pkg;
  function automatic int blind_nrnd(input int s);
    return s * (s - 1) / 2;
  endfunction
  function automatic int zw(input int s);
    return 4 * s * (s - 1);
  endfunction
  function automatic int bw(input int s);
    return 8 * blind_nrnd(s);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction
  // Inverse as b^254 by square-and-multiply (0 maps to 0), then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq, inv;
    sq = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: behavioural model of the masked S-box core (same ports and latency); output is re-shared with fresh RandomZ/RandomB.
module aes_sbox
  import aes_sbox_array_stream_pkg::*;
#(
  parameter int SHARES       = 2,
  parameter int PIPELINED    = 1,
  parameter int EIGHT_STAGED = 0,
  parameter int ZW           = zw(SHARES),
  parameter int BW           = bw(SHARES)
) (
  input  logic                ClkxCI,
  input  logic [8*SHARES-1:0] XxDI,
  input  logic [ZW-1:0]       RandomZxDI,
  input  logic [BW-1:0]       RandomBxDI,
  output logic [8*SHARES-1:0] QxDO
);
  localparam int STAGES = PIPELINED != 0 ? (EIGHT_STAGED != 0 ? 8 : 4) : 1;
  logic [7:0] w_x, w_b, w_m;
  logic [8*SHARES-1:0] w_q;
  logic [8*SHARES-1:0] r_p [STAGES];
  always_comb begin
    w_x = '0;
    for (int s = 0; s < SHARES; s++) w_x ^= XxDI[8*s +: 8];
    w_b = '0;
    for (int j = 0; j < BW / 8; j++) w_b ^= RandomBxDI[8*j +: 8];
    w_q = '0;
    for (int j = 0; j < ZW / 8; j++) w_q[8*(1 + j % (SHARES - 1)) +: 8] ^= RandomZxDI[8*j +: 8];
    w_q[15:8] ^= w_b;
    w_m = '0;
    for (int s = 1; s < SHARES; s++) w_m ^= w_q[8*s +: 8];
    w_q[7:0] = sbox(w_x) ^ w_m;
  end
  always_ff @(posedge ClkxCI) begin
    r_p[0] <= w_q;
    for (int i = 1; i < STAGES; i++) r_p[i] <= r_p[i-1];
  end
  assign QxDO = r_p[STAGES-1];
endmodule

// File: rtl/sbox_stream_fifo.sv
// sbox_stream_fifo: DEPTH-entry output FIFO; push at full is legal when a pop happens in the same cycle.
module sbox_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       ClkxCI,
  input  logic                       RstxRI,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic w_pop;
  assign w_pop = i_pop & ~o_empty;
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
    end
  end
  assign o_empty = r_cnt == '0;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/aes_sbox_array_stream.sv
// aes_sbox_array_stream: valid/ready wrapper around LANES non-stallable masked S-box cores, credits reserve FIFO slots.
// Define AES_SBOX_OUT_REFRESH_EN to add RefreshxDI, which re-randomises output shares at FIFO push.
module aes_sbox_array_stream
  import aes_sbox_array_stream_pkg::*;
#(
  parameter int SHARES  = 2,
  parameter int LANES   = 4,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int ZW      = zw(SHARES),
  parameter int BW      = bw(SHARES)
) (
  input  logic                         ClkxCI,
  input  logic                         RstxRI,
  input  logic                         InValidxSI,
  output logic                         InReadyxSO,
  input  logic [8*SHARES*LANES-1:0]    XxDI,
  input  logic                         RndValidxSI,
  input  logic [ZW*LANES-1:0]          RandomZxDI,
  input  logic [BW*LANES-1:0]          RandomBxDI,
`ifdef AES_SBOX_OUT_REFRESH_EN
  input  logic [8*(SHARES-1)*LANES-1:0] RefreshxDI,
`endif
  output logic                         OutValidxSO,
  input  logic                         OutReadyxSI,
  output logic [8*SHARES*LANES-1:0]    QxDO,
  output logic [$clog2(DEPTH+1)-1:0]   InFlightxDO
);
  localparam int DW = 8 * SHARES * LANES;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + LATENCY + 1);
  logic [LATENCY-1:0] r_vld;
  logic [DW-1:0] w_x, w_core, w_push;
  logic [CW-1:0] w_cnt;
  logic [SW-1:0] w_sum;
  logic w_fire, w_empty;
  always_comb begin
    w_sum = SW'(w_cnt);
    for (int i = 0; i < LATENCY; i++) w_sum = w_sum + SW'(r_vld[i]);
  end
  assign InReadyxSO  = RndValidxSI & (w_sum < SW'(DEPTH));
  assign w_fire      = InValidxSI & InReadyxSO;
  assign InFlightxDO = w_sum[CW-1:0];
  assign OutValidxSO = ~w_empty;
  // Idle cycles feed zero shares so nothing stale recirculates through the cores.
  assign w_x = w_fire ? XxDI : '0;
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) r_vld <= '0;
    else r_vld <= LATENCY'({r_vld, w_fire});
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox #(
      .SHARES(SHARES), .PIPELINED(1), .EIGHT_STAGED(0), .ZW(ZW), .BW(BW)
    ) u_sbox (
      .ClkxCI,
      .XxDI      (w_x[l*8*SHARES +: 8*SHARES]),
      .RandomZxDI(RandomZxDI[l*ZW +: ZW]),
      .RandomBxDI(RandomBxDI[l*BW +: BW]),
      .QxDO      (w_core[l*8*SHARES +: 8*SHARES])
    );
  end
`ifdef AES_SBOX_OUT_REFRESH_EN
  always_comb begin
    w_push = w_core;
    for (int i = 0; i < LANES; i++)
      for (int s = 1; s < SHARES; s++) begin
        w_push[(i*SHARES+s)*8 +: 8] ^= RefreshxDI[(i*(SHARES-1)+s-1)*8 +: 8];
        w_push[i*SHARES*8 +: 8] ^= RefreshxDI[(i*(SHARES-1)+s-1)*8 +: 8];
      end
  end
`else
  assign w_push = w_core;
`endif
  sbox_stream_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .ClkxCI,
    .RstxRI,
    .i_push (r_vld[LATENCY-1]),
    .i_data (w_push),
    .i_pop  (OutReadyxSI),
    .o_data (QxDO),
    .o_empty(w_empty),
    .o_count(w_cnt)
  );
endmodule

// File: tb/tb_aes_sbox_array_stream.sv
// tb_aes_sbox_array_stream: randomized scenarios checked against an unmasked AES S-box model built from GF(2^8) arithmetic.
module tb_aes_sbox_array_stream;
  localparam int S = 2, L = 4, LAT = 4, D = 6, ZW = 8, BW = 8, DW = 8 * S * L;
  logic clk = 0, rst = 1, in_valid = 0, rnd_valid = 1, out_ready = 1;
  logic in_ready, out_valid;
  logic [DW-1:0] x = '0, q;
  logic [ZW*L-1:0] rz = '0;
  logic [BW*L-1:0] rb = '0;
  logic [2:0] infl;
`ifdef AES_SBOX_OUT_REFRESH_EN
  logic [8*(S-1)*L-1:0] refr = '0;
`endif
  logic [7:0] sbox_t [256];
  logic [31:0] exp_q[$], got_q[$];
  logic [DW-1:0] raw_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  aes_sbox_array_stream #(.SHARES(S), .LANES(L), .LATENCY(LAT), .DEPTH(D)) dut (
    .ClkxCI(clk), .RstxRI(rst), .InValidxSI(in_valid), .InReadyxSO(in_ready), .XxDI(x),
    .RndValidxSI(rnd_valid), .RandomZxDI(rz), .RandomBxDI(rb),
`ifdef AES_SBOX_OUT_REFRESH_EN
    .RefreshxDI(refr),
`endif
    .OutValidxSO(out_valid), .OutReadyxSI(out_ready), .QxDO(q), .InFlightxDO(infl)
  );
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int k = 14; k >= 8; k--) if (p[k]) p ^= 15'h11b << (k - 8);
    return p[7:0];
  endfunction
  function automatic logic [31:0] unmask(input logic [DW-1:0] v);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < L; l++)
      for (int s = 0; s < S; s++) r[l*8 +: 8] ^= v[(l*S+s)*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] golden(input logic [DW-1:0] v);
    logic [31:0] u, r;
    u = unmask(v);
    for (int l = 0; l < L; l++) r[l*8 +: 8] = sbox_t[u[l*8 +: 8]];
    return r;
  endfunction
  always @(negedge clk) if (!rst) begin
    if (in_valid && in_ready) exp_q.push_back(golden(x));
    if (out_valid && out_ready) begin
      got_q.push_back(unmask(q));
      raw_q.push_back(q);
    end
  end
  task automatic drive(input logic v, input logic [31:0] bytes);
    logic [7:0] sh;
    in_valid = v;
    for (int l = 0; l < L; l++) begin
      sh = 8'($urandom);
      x[(l*S+1)*8 +: 8] = sh;
      x[l*S*8 +: 8] = bytes[l*8 +: 8] ^ sh;
    end
    rz = $urandom;
    rb = $urandom;
`ifdef AES_SBOX_OUT_REFRESH_EN
    refr = $urandom;
`endif
  endtask
  task automatic drain(output bit ok);
    ok = 0;
    drive(0, $urandom);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (infl == 0 && !out_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      drive(0, $urandom);
    end
    @(posedge clk); #1;
  endtask
  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    raw_q.delete();
  endtask
  task automatic test_reset();
    rst = 1;
    drive(0, $urandom);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", out_valid); end
    if (infl !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", infl); end
    if (q !== '0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    int n;
    bit ok;
    clear_q();
    drive(1, 32'hFF530100);
    n = 0;
    ok = 0;
    while (!ok && n < 20) begin
      @(posedge clk); #1;
      drive(0, $urandom);
      n++;
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    checks++;
    if (n != LAT + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", n, LAT + 1); end
    @(posedge clk); #1;
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL single_drain got timeout want idle"); end
    if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== 32'h16ED7C63) begin errors++; $display("FAIL single_value got %h want 16ed7c63", got_q[0]); end
    end
  endtask
  task automatic test_stream();
    int i, stalls, guard;
    bit ok;
    clear_q();
    i = 0;
    stalls = 0;
    guard = 0;
    while (i < 256 && guard < 2000) begin
      drive(1, {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)});
      @(negedge clk);
      if (in_ready) i++;
      else stalls++;
      @(posedge clk); #1;
      guard++;
    end
    drain(ok);
    checks += 3;
    if (stalls != 0) begin errors++; $display("FAIL stream_stalls got %0d want 0", stalls); end
    if (!ok) begin errors++; $display("FAIL stream_drain got timeout want idle"); end
    if (got_q.size() != 256 || exp_q.size() != 256) begin
      errors++;
      $display("FAIL stream_count got %0d want 256 (model %0d)", got_q.size(), exp_q.size());
    end else
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL stream_beat%0d got %h want %h", k, got_q[k], exp_q[k]); end
      end
  endtask
  task automatic test_backpressure();
    int acc;
    bit ok;
    clear_q();
    out_ready = 0;
    acc = 0;
    repeat (20) begin
      drive(1, $urandom);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    drive(0, $urandom);
    @(negedge clk);
    checks += 5;
    if (acc != D) begin errors++; $display("FAIL bp_accepts got %0d want %0d", acc, D); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_inready got %b want 0", in_ready); end
    if (infl !== 3'(D)) begin errors++; $display("FAIL bp_inflight got %0d want %0d", infl, D); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_outvalid got %b want 1", out_valid); end
    if (got_q.size() != 0) begin errors++; $display("FAIL bp_leak got %0d want 0", got_q.size()); end
    @(posedge clk); #1;
    out_ready = 1;
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL bp_drain got timeout want idle"); end
    if (got_q.size() != D || exp_q.size() != D) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d (model %0d)", got_q.size(), D, exp_q.size());
    end else
      for (int k = 0; k < D; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", k, got_q[k], exp_q[k]); end
      end
  endtask
  task automatic test_rnd_starve();
    int i, c;
    bit ok;
    clear_q();
    i = 0;
    c = 0;
    while (i < 30 && c < 200) begin
      rnd_valid = !(c >= 10 && c < 13);
      drive(1, $urandom);
      @(negedge clk);
      if (!rnd_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL starve_inready_c%0d got %b want 0", c, in_ready); end
      end else if (in_ready) i++;
      @(posedge clk); #1;
      c++;
    end
    rnd_valid = 1;
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL starve_drain got timeout want idle"); end
    if (got_q.size() != 30 || exp_q.size() != 30) begin
      errors++;
      $display("FAIL starve_count got %0d want 30 (model %0d)", got_q.size(), exp_q.size());
    end else
      for (int k = 0; k < 30; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL starve_beat%0d got %h want %h", k, got_q[k], exp_q[k]); end
      end
  endtask
  task automatic test_reset_midflight();
    clear_q();
    repeat (3) begin
      drive(1, $urandom);
      @(posedge clk); #1;
    end
    drive(0, $urandom);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_outvalid got %b want 0", out_valid); end
    if (infl !== 3'd0) begin errors++; $display("FAIL midrst_inflight got %0d want 0", infl); end
    if (q !== '0) begin errors++; $display("FAIL midrst_q got %h want 0", q); end
    exp_q.delete();
    repeat (10) begin
      @(posedge clk); #1;
      drive(0, $urandom);
    end
    @(negedge clk);
    checks += 2;
    if (got_q.size() != 0) begin errors++; $display("FAIL midrst_ghost got %0d want 0", got_q.size()); end
    if (infl !== 3'd0) begin errors++; $display("FAIL midrst_idle got %0d want 0", infl); end
    @(posedge clk); #1;
  endtask
`ifdef AES_SBOX_OUT_REFRESH_EN
  task automatic test_refresh();
    bit ok;
    clear_q();
    drive(1, $urandom);
    refr = 32'h01020304;
    @(posedge clk); #1;
    refr = 32'hA5A5A5A5;
    @(posedge clk); #1;
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL refresh_drain got timeout want idle"); end
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL refresh_count got %0d want 2", got_q.size());
    end else begin
      checks += 3;
      if (raw_q[0] === raw_q[1]) begin errors++; $display("FAIL refresh_shares got %h want differing", raw_q[1]); end
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL refresh_val0 got %h want %h", got_q[0], exp_q[0]); end
      if (got_q[1] !== exp_q[0]) begin errors++; $display("FAIL refresh_val1 got %h want %h", got_q[1], exp_q[0]); end
    end
  endtask
`endif
  initial begin
    logic [7:0] inv, c;
    c = 8'h63;
    for (int v = 0; v < 256; v++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul_ref(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        sbox_t[v][b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
    end
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_rnd_starve();
    test_reset_midflight();
`ifdef AES_SBOX_OUT_REFRESH_EN
    test_refresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
